// File: rtl/adder_seq_if.sv
// adder_seq_if: board-side bundle for the adder sequencing controller.
//   SW        operand value from the switches (WIDTH bits)
//   ENTER_N   raw active-low pushbutton, asynchronous to the clock
//   SUM       accumulator value (ACC_WIDTH bits)
//   COUNT     operands accumulated in the current sequence
//   BUSY      high for the single add cycle
//   DONE      high once MAX_OPS operands have been accumulated
//   OVF       sticky carry out of the accumulator
//   HEX0/HEX1 active-low seven-segment digits, bit6=g .. bit0=a
// master drives the switches/button, slave is the controller.
interface adder_seq_if #(
  parameter int WIDTH     = 5,
  parameter int ACC_WIDTH = 8
);
  logic [WIDTH-1:0]     SW;
  logic                 ENTER_N;
  logic [ACC_WIDTH-1:0] SUM;
  logic [2:0]           COUNT;
  logic                 BUSY;
  logic                 DONE;
  logic                 OVF;
  logic [6:0]           HEX0;
  logic [6:0]           HEX1;

  modport master (output SW, ENTER_N,
                  input  SUM, COUNT, BUSY, DONE, OVF, HEX0, HEX1);
  modport slave  (input  SW, ENTER_N,
                  output SUM, COUNT, BUSY, DONE, OVF, HEX0, HEX1);
endinterface

// File: rtl/adder_seq_ctrl.sv
// adder_seq_ctrl: accumulates MAX_OPS operands entered on SW, one per press
// of ENTER_N, and shows the running sum on two seven-segment digits.
//   CLOCK_50  system clock
//   RESET_N   asynchronous active-low reset, clears everything
//   bus       adder_seq_if.slave (SW, ENTER_N in; SUM, COUNT, BUSY, DONE,
//             OVF, HEX0, HEX1 out)
// Optional build macro ADDER_SEQ_DECIMAL_DISPLAY_EN: digits show SUM as
// decimal tens/units through one registered stage, "--" when SUM>=100 or
// OVF is set. Without it the digits show SUM in hex with no added latency.
module adder_seq_ctrl #(
  parameter int WIDTH     = 5,
  parameter int MAX_OPS   = 4,
  parameter int ACC_WIDTH = 8
) (
  input  logic        CLOCK_50,
  input  logic        RESET_N,
  adder_seq_if.slave  bus
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADD  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  // [0],[1] form the two-flop synchronizer; [2] holds the previous
  // synchronized level for the falling-edge detector.
  logic [2:0] sync_pipe;
  logic       enter_pulse;

  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) sync_pipe <= 3'b111;
    else          sync_pipe <= {sync_pipe[1:0], bus.ENTER_N};

  assign enter_pulse = sync_pipe[2] & ~sync_pipe[1];

  logic [1:0]           state;
  logic [WIDTH-1:0]     opnd;
  logic [ACC_WIDTH-1:0] sum;
  logic [2:0]           count;
  logic                 ovf;
  logic [ACC_WIDTH:0]   add_res;
  logic [2:0]           count_nx;

  assign add_res  = {1'b0, sum} + {{(ACC_WIDTH+1-WIDTH){1'b0}}, opnd};
  assign count_nx = count + 3'd1;

  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      state <= S_IDLE;
      opnd  <= '0;
      sum   <= '0;
      count <= '0;
      ovf   <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_WAIT:
          if (enter_pulse) begin
            opnd  <= bus.SW;
            state <= S_ADD;
          end
        S_ADD: begin
          // presses landing here are ignored
          sum   <= add_res[ACC_WIDTH-1:0];
          ovf   <= ovf | add_res[ACC_WIDTH];
          count <= count_nx;
          state <= (count_nx == 3'(MAX_OPS)) ? S_DONE : S_WAIT;
        end
        default:
          // leaving DONE clears the sequence; SW is not sampled here
          if (enter_pulse) begin
            sum   <= '0;
            count <= '0;
            ovf   <= 1'b0;
            state <= S_IDLE;
          end
      endcase
    end

  assign bus.SUM   = sum;
  assign bus.COUNT = count;
  assign bus.OVF   = ovf;
  assign bus.BUSY  = (state == S_ADD);
  assign bus.DONE  = (state == S_DONE);

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0: seg7 = 7'h40;  4'h1: seg7 = 7'h79;
      4'h2: seg7 = 7'h24;  4'h3: seg7 = 7'h30;
      4'h4: seg7 = 7'h19;  4'h5: seg7 = 7'h12;
      4'h6: seg7 = 7'h02;  4'h7: seg7 = 7'h78;
      4'h8: seg7 = 7'h00;  4'h9: seg7 = 7'h10;
      4'hA: seg7 = 7'h08;  4'hB: seg7 = 7'h03;
      4'hC: seg7 = 7'h46;  4'hD: seg7 = 7'h21;
      4'hE: seg7 = 7'h06;  default: seg7 = 7'h0E;
    endcase
  endfunction

`ifdef ADDER_SEQ_DECIMAL_DISPLAY_EN
  logic [7:0] tens, units;
  logic [6:0] hex0_q, hex1_q;

  // only meaningful when sum < 100; otherwise the dash glyph is shown
  always_comb begin
    tens  = sum[7:0] / 8'd10;
    units = sum[7:0] % 8'd10;
  end

  always_ff @(posedge CLOCK_50 or negedge RESET_N)
    if (!RESET_N) begin
      hex0_q <= 7'h40;
      hex1_q <= 7'h40;
    end else if (sum >= ACC_WIDTH'(100) || ovf) begin
      hex0_q <= 7'h3F;
      hex1_q <= 7'h3F;
    end else begin
      hex0_q <= seg7(units[3:0]);
      hex1_q <= seg7(tens[3:0]);
    end

  assign bus.HEX0 = hex0_q;
  assign bus.HEX1 = hex1_q;
`else
  assign bus.HEX0 = seg7(sum[3:0]);
  assign bus.HEX1 = seg7(sum[7:4]);
`endif

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// tb_adder_seq_ctrl: directed presses plus randomized button/switch activity
// against a transaction-level model (running integer total, operand count,
// pending add), checked every falling clock edge.
module tb_adder_seq_ctrl;
  localparam int WIDTH = 5, MAX_OPS = 4, ACC_WIDTH = 8;

  logic CLOCK_50 = 1'b0;
  logic RESET_N  = 1'b1;

  adder_seq_if #(.WIDTH(WIDTH), .ACC_WIDTH(ACC_WIDTH)) bus ();

  adder_seq_ctrl #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS), .ACC_WIDTH(ACC_WIDTH))
    dut (.CLOCK_50(CLOCK_50), .RESET_N(RESET_N), .bus(bus));

  always #5 CLOCK_50 = ~CLOCK_50;

  int checks = 0, failures = 0;

  logic [6:0] glyph [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02,
                             7'h78, 7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21,
                             7'h06, 7'h0E};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  // ENTER_N samples seen at the last three edges; a press is recognised
  // when a high sample is followed by a low one two edges earlier.
  bit h1 = 1, h2 = 1, h3 = 1;
  bit pending = 0, done = 0, pulse;
  int opnd = 0, total = 0, n = 0, disp_total = 0;

  initial forever begin
    @(posedge CLOCK_50 or negedge RESET_N);
    if (!RESET_N) begin
      h1 = 1; h2 = 1; h3 = 1;
      pending = 0; done = 0; total = 0; n = 0; disp_total = 0;
    end else begin
      pulse = h3 && !h2;
      disp_total = total;
      if (pending) begin
        total = total + opnd;
        n = n + 1;
        pending = 0;
        if (n == MAX_OPS) done = 1;
      end else if (pulse) begin
        if (done) begin
          total = 0; n = 0; done = 0;
        end else begin
          pending = 1;
          opnd = int'(bus.SW);
        end
      end
      h3 = h2; h2 = h1; h1 = bus.ENTER_N;
    end
  end

  function automatic logic [6:0] exp_hex(input bit hi);
    int s, ds;
    bit dovf;
    s = total % 256;
`ifdef ADDER_SEQ_DECIMAL_DISPLAY_EN
    ds = disp_total % 256;
    dovf = disp_total >= 256;
    if (ds >= 100 || dovf) return 7'h3F;
    return hi ? glyph[ds / 10] : glyph[ds % 10];
`else
    ds = 0; dovf = 0;
    return hi ? glyph[s / 16] : glyph[s % 16];
`endif
  endfunction

  // ---------------- compare ----------------
  initial forever begin
    @(negedge CLOCK_50);
    chk("sum",   bus.SUM,   32'(total % 256));
    chk("count", bus.COUNT, 32'(n));
    chk("busy",  bus.BUSY,  32'(pending));
    chk("done",  bus.DONE,  32'(done));
    chk("ovf",   bus.OVF,   32'(total >= 256));
    chk("hex0",  bus.HEX0,  32'(exp_hex(0)));
    chk("hex1",  bus.HEX1,  32'(exp_hex(1)));
  end

  task automatic press(input int sw, input int hold);
    @(negedge CLOCK_50);
    bus.SW = WIDTH'(sw);
    bus.ENTER_N = 1'b0;
    repeat (hold) @(negedge CLOCK_50);
    bus.ENTER_N = 1'b1;
    repeat (5) @(negedge CLOCK_50);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit found;
    bus.SW = '0;
    bus.ENTER_N = 1'b1;
    #1 RESET_N = 1'b0;
    #12;
    chk("rst_sum", bus.SUM, 0);
    chk("rst_count", bus.COUNT, 0);
    chk("rst_flags", {bus.BUSY, bus.DONE, bus.OVF}, 0);
    chk("rst_hex0", bus.HEX0, 7'h40);
    chk("rst_hex1", bus.HEX1, 7'h40);
    @(negedge CLOCK_50);
    RESET_N = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // timing: press recognised on the 3rd edge, BUSY one cycle, SUM after 4th
    bus.SW = 5'd7;
    bus.ENTER_N = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge CLOCK_50);
      chk($sformatf("tim_busy_e%0d", k), bus.BUSY, (k == 3) ? 1 : 0);
      if (k == 3) bus.SW = 5'd20;  // changed after capture, must be ignored
      if (k < 4) chk($sformatf("tim_sum_e%0d", k), bus.SUM, 0);
    end
    chk("tim_sum_e4", bus.SUM, 7);
    repeat (96) @(negedge CLOCK_50);
    chk("hold_count", bus.COUNT, 1);
    chk("hold_sum", bus.SUM, 7);
    bus.ENTER_N = 1'b1;
    repeat (3) @(negedge CLOCK_50);

    press(12, 2);
    press(31, 3);
    press(5, 6);
    chk("seq_sum", bus.SUM, 8'h37);
    chk("seq_count", bus.COUNT, 4);
    chk("seq_done", bus.DONE, 1);
`ifdef ADDER_SEQ_DECIMAL_DISPLAY_EN
    chk("seq_hex1", bus.HEX1, 7'h12);
    chk("seq_hex0", bus.HEX0, 7'h12);
`else
    chk("seq_hex1", bus.HEX1, 7'h30);
    chk("seq_hex0", bus.HEX0, 7'h78);
`endif

    press(9, 2);
    chk("exit_sum", bus.SUM, 0);
    chk("exit_count", bus.COUNT, 0);
    chk("exit_done", bus.DONE, 0);
    press(9, 2);
    chk("after_sum", bus.SUM, 9);
    chk("after_count", bus.COUNT, 1);

    // asynchronous reset while the add is in flight
    @(negedge CLOCK_50);
    bus.SW = 5'd3;
    bus.ENTER_N = 1'b0;
    found = 0;
    for (int k = 0; k < 10 && !found; k++) begin
      @(negedge CLOCK_50);
      if (bus.BUSY) found = 1;
    end
    chk("midadd_busy_seen", found, 1);
    #2 RESET_N = 1'b0;
    #1;
    chk("midrst_sum", bus.SUM, 0);
    chk("midrst_count", bus.COUNT, 0);
    chk("midrst_busy", bus.BUSY, 0);
    chk("midrst_hex0", bus.HEX0, 7'h40);
    chk("midrst_hex1", bus.HEX1, 7'h40);
    #1;
    bus.ENTER_N = 1'b1;
    RESET_N = 1'b1;
    repeat (2) @(negedge CLOCK_50);

    // random button chatter and switches, with occasional async resets
    repeat (4000) begin
      @(negedge CLOCK_50);
      bus.SW = WIDTH'($urandom);
      if ($urandom_range(0, 2) == 0) bus.ENTER_N = ~bus.ENTER_N;
      if ($urandom_range(0, 599) == 0) begin
        #1 RESET_N = 1'b0;
        #2 RESET_N = 1'b1;
      end
    end

    @(negedge CLOCK_50);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/adder_seq_ctrl.md
Name: adder_seq_ctrl

Overview:
- Sequencing controller for the board adder/display path. Operator enters MAX_OPS operands one at a time on SW and confirms each with a pushbutton.
- Block accumulates the operands through a registered add datapath and drives two active-low seven-segment digits with the running sum.
- Sits at top level between board switches/keys and HEX0/HEX1.

Parameters:
- WIDTH, 5, operand width taken from SW.
- MAX_OPS, 4, operands per sequence, range 2..7.
- ACC_WIDTH, 8, accumulator width; HEX shows ACC[7:0].

Ports:
- CLOCK_50  in  1  system clock, 50 MHz.
- RESET_N  in  1  asynchronous, active-low reset; clears all state.
- SW  in  WIDTH  operand value.
- ENTER_N  in  1  raw pushbutton, active-low, asynchronous to clock.
- SUM  out  ACC_WIDTH  accumulator value.
- COUNT  out  3  operands accumulated so far.
- BUSY  out  1  high in ADD state.
- DONE  out  1  high in DONE state.
- OVF  out  1  sticky: carry out of ACC_WIDTH occurred.
- HEX0  out  7  low display digit, active-low, bit6=g..bit0=a.
- HEX1  out  7  high display digit, same encoding.

Behaviour:
- Reset (async assert, sync-safe deassert):
  - SUM=0, COUNT=0, OVF=0, BUSY=0, DONE=0, state IDLE.
  - Synchronizer flops reset to 1 (button released).
  - HEX0=HEX1=7'b1000000 ("0").
- Input conditioning:
  - ENTER_N passes through a 2-flop synchronizer, then a falling-edge detector, producing a one-cycle enter_pulse.
  - enter_pulse is high on the 3rd rising edge after ENTER_N goes low.
  - A held button produces exactly one pulse; no debounce filtering.
- FSM:
  - IDLE: enter_pulse -> OPND<=SW, state ADD.
  - ADD (1 cycle, BUSY=1): {carry,SUM}<=SUM+zero-extended OPND; OVF<=OVF|carry; COUNT<=COUNT+1; if COUNT+1==MAX_OPS -> DONE, else WAIT. Any enter_pulse in ADD is dropped.
  - WAIT: enter_pulse -> OPND<=SW, state ADD.
  - DONE (DONE=1): SUM and COUNT held; enter_pulse -> SUM=0, COUNT=0, OVF=0, state IDLE. SW is not captured on this pulse.
- Latency: SUM updates on the 2nd edge after enter_pulse (capture edge, then ADD edge). HEX updates combinationally from SUM, same cycle.
- Arithmetic: unsigned; SUM wraps modulo 2^ACC_WIDTH on overflow; OVF stays set until the DONE-exit pulse or reset.
- Display: HEX0=seg(SUM[3:0]), HEX1=seg(SUM[7:4]), standard hex glyphs 0-F, inverted (active-low).
- Reset mid-sequence: immediate clear to reset values; any partially entered sequence is discarded.
- SW changing between capture and ADD has no effect; OPND is registered.

Optional Feature:
- Macro: ADDER_SEQ_DECIMAL_DISPLAY_EN.
- Defined:
  - HEX1/HEX0 show SUM mod 100 as decimal tens/units.
  - A registered binary-to-BCD stage adds 1 cycle of display latency vs SUM.
  - When SUM>=100 or OVF=1, both digits show "-" (7'b0111111).
- Undefined: hex display as above, zero added latency, no BCD logic synthesized.

Test Plan:
- Reset: assert RESET_N=0 mid-ADD -> SUM=0, COUNT=0, OVF=0, state IDLE, HEX1=HEX0=7'h40, asynchronously with no clock edge needed.
- Sequence: enter SW=7,12,31,5 with one press each -> SUM=8'h37, COUNT=4, DONE=1, HEX1=7'h30 ("3"), HEX0=7'h78 ("7").
- Timing: single press -> enter_pulse on 3rd edge after ENTER_N low; BUSY high exactly 1 cycle; SUM valid 2 edges after the pulse.
- Hold/edge: ENTER_N held low 100 cycles -> exactly one operand accumulated, COUNT=1. SW changed 1 cycle after capture -> not used.
- DONE exit: in DONE with SW=9, press -> SUM=0, COUNT=0, state IDLE. The next press with SW=9 gives SUM=9.
- Decimal (macro defined): sequence 7,12,31,5 -> HEX1=HEX0=7'h12 ("55"), one cycle after SUM update. MAX_OPS=7 with all 31 -> SUM=217 -> both digits "-".
